i2c_temp_responder: RTL



---
 rtl/i2c_temp_responder_if.sv | 15 +
 rtl/i2c_temp_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_responder_if.sv
// i2c_temp_responder_if
// Groups the open-drain I2C bus lines seen by the temperature responder.
//   SCL_i       bus clock level
//   SDA_i       bus data level (wired-AND of all drivers)
//   SDA_LowEn_o 1 = responder pulls SDA low, 0 = released
// The master modport belongs to whoever drives the bus clock and data
// levels; the slave modport belongs to the responder.
interface i2c_temp_responder_if;
    logic SCL_i;
    logic SDA_i;
    logic SDA_LowEn_o;

    modport master (output SCL_i, output SDA_i, input SDA_LowEn_o);
    modport slave  (input SCL_i, input SDA_i, output SDA_LowEn_o);
endinterface

// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder
// I2C slave that emulates the ADT7410 register set (TempMSB 0x00,
// TempLSB 0x01, Config 0x03). It also runs a one-shot conversion timer that
// loads the temperature registers from TempValue_i when it finishes.
// Ports:
//   Clk_i, Reset_n_i  system clock, asynchronous active-low reset
//   bus               SCL/SDA levels in, SDA pull-down enable out
//   TempValue_i       value loaded into {TempMSB, TempLSB} when a conversion ends
//   ParamConvDelay_i  conversion time in Clk_i cycles
//   Converting_o      a one-shot conversion is in progress
//   ConvDone_o        one-cycle pulse when a conversion ends
//   Config_o          current config register
module i2c_temp_responder #(
    parameter logic [6:0] DevAddr = 7'b1001000
) (
    input  logic                        Clk_i,
    input  logic                        Reset_n_i,
    i2c_temp_responder_if.slave         bus,
    input  logic [15:0]                 TempValue_i,
    input  logic [15:0]                 ParamConvDelay_i,
    output logic                        Converting_o,
    output logic                        ConvDone_o,
    output logic [7:0]                  Config_o
);

    typedef enum logic [3:0] {
        stIdle, stAddr, stAddrAck, stRxPtr, stRxData,
        stRxAck, stTxByte, stMAck, stIgnore
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync, sda_sync;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_low_q, sda_low_d;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic [7:0]  byte_in;
    logic [7:0]  temp_msb_q, temp_lsb_q, config_q;
    logic [15:0] conv_cnt_q;
    logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic        trigger;

    // Stage 0/1 synchronise; stage 2 holds the previous level for edge
    // detection. Reset to 1 so an idle bus produces no spurious edges.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], bus.SCL_i};
            sda_sync <= {sda_sync[1:0], bus.SDA_i};
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
    assign stop_det  = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];
    assign byte_in   = {shift_q[6:0], sda_s};

    always_comb begin
        case (ptr_q)
            8'h00:   rd_data = temp_msb_q;
            8'h01:   rd_data = temp_lsb_q;
            8'h03:   rd_data = config_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q   <= stIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_low_q <= sda_low_d;
        end
    end

    // SDA only changes on SCL falling edges, except that START/STOP
    // release it at once. bit_cnt == 8 in a receive state means "byte
    // complete, waiting for the falling edge that opens the ACK slot".
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_low_d = sda_low_q;
        wr_en     = 1'b0;
        wr_data   = byte_in;

        if (start_det) begin
            state_d   = stAddr;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = stIdle;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                stAddr, stRxPtr, stRxData: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == stRxPtr) begin
                                ptr_d = byte_in;
                            end else if (state_q == stRxData) begin
                                wr_en = 1'b1;
                                ptr_d = ptr_q + 8'd1;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == stAddr && shift_q[7:1] != DevAddr) begin
                            state_d = stIgnore;
                        end else begin
                            state_d   = (state_q == stAddr) ? stAddrAck : stRxAck;
                            sda_low_d = 1'b1;
                        end
                    end
                end
                stAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            shift_d   = rd_data;
                            sda_low_d = ~rd_data[7];
                            state_d   = stTxByte;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = stRxPtr;
                        end
                    end
                end
                stRxAck: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = stRxData;
                    end
                end
                stTxByte: begin
                    // bit_cnt counts bits the master has already clocked in.
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = stMAck;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_low_d = ~shift_q[6];
                    end
                end
                stMAck: begin
                    // bit_cnt == 1 marks "master ACKed, reload on next fall".
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        ptr_d = ptr_q + 8'd1;
                        if (sda_s) begin
                            state_d = stIgnore;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shift_d   = rd_data;
                        sda_low_d = ~rd_data[7];
                        bit_cnt_d = 4'd0;
                        state_d   = stTxByte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SDA_LowEn_o = sda_low_q;

    assign trigger = wr_en && (ptr_q == 8'h03) && (wr_data[6:5] == 2'b01);

    // Register file and one-shot timer. A trigger always reloads the
    // counter, so a retrigger mid-conversion restarts the full delay.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            temp_msb_q   <= 8'h00;
            temp_lsb_q   <= 8'h00;
            config_q     <= 8'h00;
            conv_cnt_q   <= 16'd0;
            Converting_o <= 1'b0;
            ConvDone_o   <= 1'b0;
        end else begin
            ConvDone_o <= 1'b0;
            if (trigger) begin
                conv_cnt_q   <= ParamConvDelay_i;
                Converting_o <= 1'b1;
            end else if (Converting_o) begin
                if (conv_cnt_q == 16'd0) begin
                    {temp_msb_q, temp_lsb_q} <= TempValue_i;
                    ConvDone_o   <= 1'b1;
                    Converting_o <= 1'b0;
                end else begin
                    conv_cnt_q <= conv_cnt_q - 16'd1;
                end
            end

            if (wr_en && ptr_q == 8'h03) begin
                config_q <= wr_data;
            end else if (Converting_o && !trigger && conv_cnt_q == 16'd0) begin
                config_q[6:5] <= 2'b11;
            end
        end
    end

    assign Config_o = config_q;

endmodule
